// File: rtl/ex_mem_latch_if.sv
// Execute-to-memory stage bundle: pipeline controls, EX-side fields, MEM-side registered fields.
// Pure wiring; no storage or latency of its own.
// Hold/flush travel with the bundle; the EX side drives them, the latch obeys them.
interface ex_mem_latch_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
);
  // pipeline control
  logic              en;
  logic              flush;
  logic              exc_ack;
  // execute-stage side
  logic              ex_valid;
  logic [WORD_W-1:0] ex_out;
  logic              ex_zero;
  logic              ex_neg;
  logic              ex_overflow;
  logic              ex_trap_en;
  logic [WORD_W-1:0] ex_rtdata;
  logic [WORD_W-1:0] ex_npc;
  logic [REG_W-1:0]  ex_wsel;
  logic              ex_regwen;
  logic              ex_dren;
  logic              ex_dwen;
  logic              ex_memtoreg;
  logic              ex_halt;
  // memory-stage side
  logic              mem_valid;
  logic [WORD_W-1:0] mem_out;
  logic              mem_zero;
  logic              mem_neg;
  logic [WORD_W-1:0] mem_rtdata;
  logic [WORD_W-1:0] mem_npc;
  logic [REG_W-1:0]  mem_wsel;
  logic              mem_regwen;
  logic              mem_dren;
  logic              mem_dwen;
  logic              mem_memtoreg;
  logic              mem_halt;
  logic              exc_pending;
  logic [WORD_W-1:0] exc_epc;
  logic [CNT_W-1:0]  ovf_count;

  // execute stage / pipeline controller side
  modport master (
    output en, flush, exc_ack,
    output ex_valid, ex_out, ex_zero, ex_neg, ex_overflow, ex_trap_en,
    output ex_rtdata, ex_npc, ex_wsel, ex_regwen, ex_dren, ex_dwen,
    output ex_memtoreg, ex_halt,
    input  mem_valid, mem_out, mem_zero, mem_neg, mem_rtdata, mem_npc,
    input  mem_wsel, mem_regwen, mem_dren, mem_dwen, mem_memtoreg,
    input  mem_halt, exc_pending, exc_epc, ovf_count
  );

  // the EX/MEM latch itself
  modport slave (
    input  en, flush, exc_ack,
    input  ex_valid, ex_out, ex_zero, ex_neg, ex_overflow, ex_trap_en,
    input  ex_rtdata, ex_npc, ex_wsel, ex_regwen, ex_dren, ex_dwen,
    input  ex_memtoreg, ex_halt,
    output mem_valid, mem_out, mem_zero, mem_neg, mem_rtdata, mem_npc,
    output mem_wsel, mem_regwen, mem_dren, mem_dwen, mem_memtoreg,
    output mem_halt, exc_pending, exc_epc, ovf_count
  );
endinterface

// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register with overflow trap, sticky exception record and saturating trap counter.
// Latency: 1 cycle, every output registered, no input-to-output combinational path.
// Backpressure: en=0 holds the stage; flush loads a bubble and overrides en.
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input logic           CLK,
  input logic           nRST,
  ex_mem_latch_if.slave bus
);

  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  logic capture;
  logic trap;
  logic take_epc;

  // Decode this edge's action; a held instruction is only judged on the edge it captures.
  // Once halted, captures still flow but can no longer raise a trap.
  always_comb begin
    capture  = bus.en && !bus.flush;
    trap     = capture && bus.ex_valid && bus.ex_trap_en && bus.ex_overflow && !bus.mem_halt;
    // first trap records its PC; a trap colliding with an ack starts a fresh record
    take_epc = trap && (!bus.exc_pending || bus.exc_ack);
  end

  // Pipeline fields: flush loads a bubble, en=0 holds, otherwise capture EX.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.mem_valid    <= 1'b0;
      bus.mem_out      <= '0;
      bus.mem_zero     <= 1'b0;
      bus.mem_neg      <= 1'b0;
      bus.mem_rtdata   <= '0;
      bus.mem_npc      <= '0;
      bus.mem_wsel     <= '0;
      bus.mem_regwen   <= 1'b0;
      bus.mem_dren     <= 1'b0;
      bus.mem_dwen     <= 1'b0;
      bus.mem_memtoreg <= 1'b0;
    end else if (bus.flush) begin
      bus.mem_valid    <= 1'b0;
      bus.mem_out      <= '0;
      bus.mem_zero     <= 1'b0;
      bus.mem_neg      <= 1'b0;
      bus.mem_rtdata   <= '0;
      bus.mem_npc      <= '0;
      bus.mem_wsel     <= '0;
      bus.mem_regwen   <= 1'b0;
      bus.mem_dren     <= 1'b0;
      bus.mem_dwen     <= 1'b0;
      bus.mem_memtoreg <= 1'b0;
    end else if (bus.en) begin
      bus.mem_valid    <= bus.ex_valid;
      bus.mem_out      <= bus.ex_out;
      bus.mem_zero     <= bus.ex_zero;
      bus.mem_neg      <= bus.ex_neg;
      bus.mem_rtdata   <= bus.ex_rtdata;
      bus.mem_npc      <= bus.ex_npc;
      bus.mem_wsel     <= bus.ex_wsel;
      // a trapped instruction stays valid but must not touch registers or memory
      bus.mem_regwen   <= bus.ex_valid && bus.ex_regwen && !trap;
      bus.mem_dren     <= bus.ex_valid && bus.ex_dren && !trap;
      bus.mem_dwen     <= bus.ex_valid && bus.ex_dwen && !trap;
      bus.mem_memtoreg <= bus.ex_valid && bus.ex_memtoreg;
    end
  end

  // Sticky halt: set by a captured valid HALT, survives flush, cleared only by reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.mem_halt <= 1'b0;
    end else if (capture && bus.ex_valid && bus.ex_halt) begin
      bus.mem_halt <= 1'b1;
    end
  end

  // Exception record: a new trap beats a same-edge ack; otherwise ack clears pending.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.exc_pending <= 1'b0;
      bus.exc_epc     <= '0;
    end else begin
      if (trap) begin
        bus.exc_pending <= 1'b1;
      end else if (bus.exc_ack) begin
        bus.exc_pending <= 1'b0;
      end
      if (take_epc) begin
        bus.exc_epc <= bus.ex_npc - PC_STEP;
      end
    end
  end

  // Trap counter, saturating at all-ones.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.ovf_count <= '0;
    end else if (trap && (bus.ovf_count != CNT_MAX)) begin
      bus.ovf_count <= bus.ovf_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_latch.sv
// Testbench for ex_mem_latch: random traffic against a reference model plus directed scenarios.
// Checks every output one time unit after each rising edge, and during asynchronous reset.
// Drives hold/flush/ack randomly to exercise stalls, bubbles and exception acknowledgement.
module tb_ex_mem_latch;
  localparam int WORD_W  = 32;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_latch_if #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  ex_mem_latch #(.WORD_W(WORD_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK (clk),
    .nRST(nrst),
    .bus (bus)
  );

  // reference model state (expected outputs)
  logic              m_valid, m_zero, m_neg, m_regwen, m_dren, m_dwen, m_memtoreg;
  logic              m_halt, m_exc;
  logic [WORD_W-1:0] m_out, m_rtdata, m_npc, m_epc;
  logic [REG_W-1:0]  m_wsel;
  int                m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_zero = 0; m_neg = 0; m_regwen = 0; m_dren = 0; m_dwen = 0;
    m_memtoreg = 0; m_halt = 0; m_exc = 0;
    m_out = 0; m_rtdata = 0; m_npc = 0; m_epc = 0; m_wsel = 0; m_cnt = 0;
  endtask

  // One clock edge of the architectural rules, evaluated from the pre-edge inputs.
  task automatic model_edge();
    bit cap, trap;
    cap  = bus.en && !bus.flush;
    trap = cap && bus.ex_valid && bus.ex_trap_en && bus.ex_overflow && !m_halt;
    if (trap) begin
      if (!m_exc || bus.exc_ack) m_epc = bus.ex_npc - 32'd4;
      m_exc = 1;
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (bus.exc_ack) begin
      m_exc = 0;
    end
    if (cap && bus.ex_valid && bus.ex_halt) m_halt = 1;
    if (bus.flush) begin
      m_valid = 0; m_regwen = 0; m_dren = 0; m_dwen = 0; m_memtoreg = 0;
      m_out = 0; m_zero = 0; m_neg = 0; m_rtdata = 0; m_npc = 0; m_wsel = 0;
    end else if (bus.en) begin
      m_valid    = bus.ex_valid;
      m_out      = bus.ex_out;
      m_zero     = bus.ex_zero;
      m_neg      = bus.ex_neg;
      m_rtdata   = bus.ex_rtdata;
      m_npc      = bus.ex_npc;
      m_wsel     = bus.ex_wsel;
      m_regwen   = bus.ex_valid && bus.ex_regwen && !trap;
      m_dren     = bus.ex_valid && bus.ex_dren && !trap;
      m_dwen     = bus.ex_valid && bus.ex_dwen && !trap;
      m_memtoreg = bus.ex_valid && bus.ex_memtoreg;
    end
  endtask

  task automatic check_all();
    chk("mem_valid", bus.mem_valid, m_valid);
    chk("mem_out", bus.mem_out, m_out);
    chk("mem_zero", bus.mem_zero, m_zero);
    chk("mem_neg", bus.mem_neg, m_neg);
    chk("mem_rtdata", bus.mem_rtdata, m_rtdata);
    chk("mem_npc", bus.mem_npc, m_npc);
    chk("mem_wsel", bus.mem_wsel, m_wsel);
    chk("mem_regwen", bus.mem_regwen, m_regwen);
    chk("mem_dren", bus.mem_dren, m_dren);
    chk("mem_dwen", bus.mem_dwen, m_dwen);
    chk("mem_memtoreg", bus.mem_memtoreg, m_memtoreg);
    chk("mem_halt", bus.mem_halt, m_halt);
    chk("exc_pending", bus.exc_pending, m_exc);
    chk("exc_epc", bus.exc_epc, m_epc);
    chk("ovf_count", bus.ovf_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic tick_fast();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Reset pulse placed between edges; outputs must clear before any edge arrives.
  task automatic do_reset();
    nrst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_halt", bus.mem_halt, 1'b0);
    chk("arst_cnt", bus.ovf_count, 16'h0);
    #1;
    nrst = 1'b1;
  endtask

  task automatic set_idle();
    bus.en = 1; bus.flush = 0; bus.exc_ack = 0;
    bus.ex_valid = 0; bus.ex_out = 0; bus.ex_zero = 0; bus.ex_neg = 0;
    bus.ex_overflow = 0; bus.ex_trap_en = 0; bus.ex_rtdata = 0; bus.ex_npc = 0;
    bus.ex_wsel = 0; bus.ex_regwen = 0; bus.ex_dren = 0; bus.ex_dwen = 0;
    bus.ex_memtoreg = 0; bus.ex_halt = 0;
  endtask

  task automatic set_instr(input logic [31:0] out, input logic [31:0] npc, input logic trap_en,
                           input logic ovf, input logic neg);
    set_idle();
    bus.ex_valid = 1; bus.ex_out = out; bus.ex_npc = npc; bus.ex_wsel = 5'd5;
    bus.ex_regwen = 1; bus.ex_trap_en = trap_en; bus.ex_overflow = ovf; bus.ex_neg = neg;
  endtask

  task automatic rand_inputs(input bit allow_halt);
    bus.en          = ($urandom_range(0, 99) < 80);
    bus.flush       = ($urandom_range(0, 99) < 10);
    bus.exc_ack     = ($urandom_range(0, 99) < 10);
    bus.ex_valid    = ($urandom_range(0, 99) < 80);
    bus.ex_out      = $urandom;
    bus.ex_zero     = 1'($urandom);
    bus.ex_neg      = 1'($urandom);
    bus.ex_overflow = ($urandom_range(0, 99) < 30);
    bus.ex_trap_en  = 1'($urandom);
    bus.ex_rtdata   = $urandom;
    bus.ex_npc      = $urandom;
    bus.ex_wsel     = 5'($urandom);
    bus.ex_regwen   = 1'($urandom);
    bus.ex_dren     = 1'($urandom);
    bus.ex_dwen     = 1'($urandom);
    bus.ex_memtoreg = 1'($urandom);
    bus.ex_halt     = allow_halt && ($urandom_range(0, 99) < 5);
  endtask

  initial begin
    set_idle();
    model_reset();
    #1 nrst = 1'b0;
    #1 check_all();
    #1 nrst = 1'b1;

    // random traffic without HALT
    repeat (1500) begin
      rand_inputs(1'b0);
      tick();
    end

    // normal pass-through
    do_reset();
    set_instr(32'h0000_0010, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pass_out", bus.mem_out, 32'h10);
    chk("pass_wsel", bus.mem_wsel, 5'd5);
    chk("pass_regwen", bus.mem_regwen, 1'b1);
    chk("pass_zero", bus.mem_zero, 1'b0);
    chk("pass_exc", bus.exc_pending, 1'b0);

    // hold then flush
    set_instr(32'hDEAD_BEEF, 32'h0000_0048, 1'b0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b0);
      bus.en = 0; bus.flush = 0; bus.exc_ack = 0;
      tick();
      chk("hold_out", bus.mem_out, 32'hDEAD_BEEF);
    end
    set_idle();
    bus.flush = 1;
    bus.ex_valid = 1; bus.ex_regwen = 1; bus.ex_out = 32'h1234_5678;
    tick();
    chk("flush_valid", bus.mem_valid, 1'b0);
    chk("flush_regwen", bus.mem_regwen, 1'b0);
    chk("flush_out", bus.mem_out, 32'h0);

    // trapped overflow, then a second trap before any ack
    set_instr(32'h8000_0000, 32'h0000_0104, 1'b1, 1'b1, 1'b1);
    tick();
    chk("trap_regwen", bus.mem_regwen, 1'b0);
    chk("trap_valid", bus.mem_valid, 1'b1);
    chk("trap_neg", bus.mem_neg, 1'b1);
    chk("trap_exc", bus.exc_pending, 1'b1);
    chk("trap_epc", bus.exc_epc, 32'h100);
    chk("trap_cnt", bus.ovf_count, 16'd1);
    set_instr(32'h8000_0000, 32'h0000_0200, 1'b1, 1'b1, 1'b1);
    tick();
    chk("trap2_epc", bus.exc_epc, 32'h100);
    chk("trap2_cnt", bus.ovf_count, 16'd2);

    // ack colliding with a trap, then ack alone
    set_instr(32'h8000_0000, 32'h0000_0304, 1'b1, 1'b1, 1'b1);
    bus.exc_ack = 1;
    tick();
    chk("coll_exc", bus.exc_pending, 1'b1);
    chk("coll_epc", bus.exc_epc, 32'h300);
    set_idle();
    bus.exc_ack = 1;
    tick();
    chk("ack_exc", bus.exc_pending, 1'b0);

    // unsigned overflow commits normally
    set_instr(32'h0000_0000, 32'h0000_0404, 1'b0, 1'b1, 1'b0);
    tick();
    chk("uns_regwen", bus.mem_regwen, 1'b1);
    chk("uns_exc", bus.exc_pending, 1'b0);
    chk("uns_cnt", bus.ovf_count, 16'd3);

    // trap held by en=0 counts once, on the capturing edge
    set_instr(32'h8000_0000, 32'h0000_0504, 1'b1, 1'b1, 1'b1);
    bus.en = 0;
    tick();
    tick();
    chk("held_cnt", bus.ovf_count, 16'd3);
    chk("held_exc", bus.exc_pending, 1'b0);
    bus.en = 1;
    tick();
    chk("rel_cnt", bus.ovf_count, 16'd4);
    chk("rel_epc", bus.exc_epc, 32'h500);
    set_idle();
    tick();
    chk("rel_once", bus.ovf_count, 16'd4);

    // saturation: 65535 traps then one more
    do_reset();
    set_instr(32'h8000_0000, 32'h0000_0604, 1'b1, 1'b1, 1'b1);
    repeat (CNT_MAX) tick_fast();
    check_all();
    chk("sat_full", bus.ovf_count, 16'hFFFF);
    tick();
    chk("sat_stay", bus.ovf_count, 16'hFFFF);

    // halt is sticky through flush and blocks later traps
    do_reset();
    set_idle();
    bus.ex_valid = 1; bus.ex_halt = 1;
    tick();
    chk("halt_set", bus.mem_halt, 1'b1);
    set_idle();
    bus.flush = 1;
    tick();
    chk("halt_flush", bus.mem_halt, 1'b1);
    set_instr(32'h8000_0000, 32'h0000_0704, 1'b1, 1'b1, 1'b1);
    tick();
    chk("halt_notrap", bus.exc_pending, 1'b0);
    chk("halt_nocnt", bus.ovf_count, 16'd0);
    chk("halt_out", bus.mem_out, 32'h8000_0000);

    // random traffic with HALT allowed, starting from a fresh reset
    do_reset();
    repeat (300) begin
      rand_inputs(1'b1);
      tick();
    end

    // reset mid-trap: pending exception and stalled stage cleared at once
    set_instr(32'h8000_0000, 32'h0000_0804, 1'b1, 1'b1, 1'b1);
    tick();
    bus.en = 0;
    tick();
    #2;
    do_reset();
    set_idle();
    repeat (20) begin
      rand_inputs(1'b0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_latch.md
Name: ex_mem_latch

Overview:
- Pipeline register between the execute stage (ALU results and operands) and the memory stage of each core in the dual-core pipeline.
- Captures the ALU result and status flags, store data, destination register and memory/writeback control.
- Applies pipeline hold and flush.
- Converts a signed-arithmetic overflow into a squashed, trapped instruction with a sticky exception record and a saturating overflow counter.

Parameters:
- WORD_W, 32, data and address width.
- REG_W, 5, register-index width.
- CNT_W, 16, overflow event counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  advance enable (high when the memory stage is not stalled).
- flush  in  1  squash: load a bubble.
- ex_valid  in  1  execute stage holds a real instruction.
- ex_out  in  WORD_W  ALU result.
- ex_zero  in  1  ALU zero flag.
- ex_neg  in  1  ALU negative flag.
- ex_overflow  in  1  ALU signed overflow.
- ex_trap_en  in  1  instruction traps on overflow (ADD/SUB/ADDI, not the unsigned forms).
- ex_rtdata  in  WORD_W  store data.
- ex_npc  in  WORD_W  PC+4 of the instruction.
- ex_wsel  in  REG_W  destination register.
- ex_regwen  in  1  register write.
- ex_dren  in  1  data read.
- ex_dwen  in  1  data write.
- ex_memtoreg  in  1  writeback source select.
- ex_halt  in  1  HALT instruction.
- exc_ack  in  1  clears the sticky exception record.
- mem_valid  out  1  registered valid.
- mem_out  out  WORD_W  registered ALU result (data address).
- mem_zero  out  1  registered zero flag.
- mem_neg  out  1  registered negative flag.
- mem_rtdata  out  WORD_W  registered store data.
- mem_npc  out  WORD_W  registered PC+4.
- mem_wsel  out  REG_W  registered destination register.
- mem_regwen  out  1  registered register write.
- mem_dren  out  1  registered data read.
- mem_dwen  out  1  registered data write.
- mem_memtoreg  out  1  registered writeback select.
- mem_halt  out  1  sticky halt.
- exc_pending  out  1  sticky overflow exception.
- exc_epc  out  WORD_W  PC of the trapping instruction (ex_npc - 4).
- ovf_count  out  CNT_W  saturating count of trapped overflows.

Behaviour:
- Reset (nRST low, asynchronous): every output is 0; the counter is cleared.
- All updates occur on the rising edge of CLK. Every output is registered (1-cycle latency), with no combinational input-to-output path.
- Priority per edge: flush > hold (en=0) > capture.
- flush=1: load a bubble regardless of en.
  - mem_valid, mem_regwen, mem_dren, mem_dwen and mem_memtoreg go to 0.
  - Data fields go to 0.
  - mem_halt, exc_pending, exc_epc and ovf_count are unaffected.
- en=0 and flush=0: all pipeline outputs hold their values.
- Capture (en=1, flush=0):
  - All mem_* fields take the matching ex_* values, and mem_valid takes ex_valid.
  - When ex_valid=0, the control enables (regwen/dren/dwen/memtoreg) are forced to 0.
- Trap condition: capture && ex_valid && ex_trap_en && ex_overflow. On a trap:
  - mem_regwen, mem_dren and mem_dwen are forced to 0; mem_valid stays 1 and data fields are captured normally.
  - If exc_pending=0, exc_pending goes to 1 and exc_epc takes ex_npc-4 (mod 2^WORD_W).
  - If exc_pending=1, exc_epc keeps the first trap and is not overwritten.
  - ovf_count increments, saturating at 2^CNT_W-1.
- Overflow with ex_trap_en=0: no trap; the instruction commits normally.
- Overflow while flush=1 or en=0: no trap and no count. A held instruction is evaluated again on the edge where it finally captures.
- exc_ack: clears exc_pending on the next edge.
  - If exc_ack coincides with a new trap, the new trap wins: exc_pending stays 1 and exc_epc is reloaded with the new PC.
- mem_halt:
  - Set on capture of a valid instruction with ex_halt=1.
  - Once set, it stays 1 until reset and is not cleared by flush.
  - After mem_halt is set, further captures still update the pipeline fields but cannot set a trap.
- Back-to-back captures impose no bubble requirement.
- Reset asserted mid-stall or mid-trap returns every output to the reset state immediately.

Test Plan:
- Normal pass-through:
  - Stimulus: en=1, valid ADD with ex_out=0x0000_0010, wsel=5, regwen=1, no overflow.
  - Required: next cycle mem_out=0x10, mem_wsel=5, mem_regwen=1, mem_zero=0, exc_pending=0.
- Hold then flush:
  - Stimulus: capture ex_out=0xDEAD_BEEF; en=0 for 3 cycles with changing inputs; then flush=1.
  - Required: mem_out stays 0xDEADBEEF during the hold; after the flush edge mem_valid=0, mem_regwen=0 and mem_out=0.
- Trapped overflow:
  - Stimulus: ex_npc=0x0000_0104, trap_en=1, overflow=1 (0x7FFF_FFFF+1, ex_out=0x8000_0000).
  - Required: mem_regwen=0, mem_neg=1, exc_pending=1, exc_epc=0x0000_0100, ovf_count=1.
  - Follow-on: a second trap at npc 0x200 before any ack leaves exc_epc=0x100 and gives ovf_count=2.
- Ack versus trap collision:
  - Stimulus: exc_ack=1 on the same edge as a trap at npc=0x0000_0304.
  - Required: exc_pending=1, exc_epc=0x300.
  - Follow-on: exc_ack alone on the next edge gives exc_pending=0.
- Unsigned and gated cases:
  - Stimulus 1: overflow=1 with trap_en=0. Required: mem_regwen=1, no exception.
  - Stimulus 2: overflow=1 with trap_en=1 during en=0, then en=1. Required: exactly one count.
  - Stimulus 3: ovf_count preloaded to 0xFFFF by 65535 traps, then one more trap. Required: ovf_count stays 0xFFFF.
- Halt and reset:
  - Stimulus: capture valid ex_halt=1; then flush.
  - Required: mem_halt stays 1 through the flush.
  - Stimulus: assert nRST low between clock edges.
  - Required: all outputs 0 immediately, before the next edge.
